pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipeline (Fetch, Decode, Exec, Mem, WB). It owns the enable and flush controls of every inter-stage register bank:

- a start-up drain after reset,
- load-use stalls between Decode and Exec,
- taken-branch/jump flushes resolved in Exec,
- freezes while the Mem stage reports a multi-cycle IO/memory access.

It also keeps saturating stall/flush counters and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- REG_INDEX_BIT_WIDTH, 4, register index width
- CNT_BITS, 16, width of stallCount/flushCount
- STARTUP_CYCLES, 4, bubble cycles after reset release before fetch starts (>=1)
- MEM_TIMEOUT, 256, consecutive mBusy cycles that set memTimeout (>=1)

Ports:
- clk  in  1  pipeline clock. One clock; reset is asynchronous and active-low.
- reset  in  1  asynchronous, active-low reset
- dRegno1, dRegno2  in  REG_INDEX_BIT_WIDTH  source registers of the instruction in Decode
- dUsesRs1, dUsesRs2  in  1  Decode instruction actually reads that source
- eRd  in  REG_INDEX_BIT_WIDTH  destination of the instruction in Exec
- eRegfileWrtEn  in  1  Exec instruction writes the regfile
- eIsLoad  in  1  Exec instruction is a load (value available only after Mem)
- eRedirect  in  1  Exec resolved a taken branch or jump (PC redirected)
- mBusy  in  1  Mem stage access not complete this cycle
- fetchEn, decodeEn, execEn, memEn  out  1  load enables for PC, D, E and M register banks
- decodeFlush, execFlush  out  1  D or E bank loads a bubble (NOOP, wrtEn=0, isStore=0) instead of its input
- wbBubble  out  1  WB bank loads a bubble
- state  out  2  0=STARTUP, 1=RUN, 2=MEM_WAIT
- stallCount, flushCount  out  CNT_BITS  saturating event counters
- memTimeout  out  1  sticky timeout flag

## Operation
- Load-use hazard: loadUse = eIsLoad & eRegfileWrtEn & ((dUsesRs1 & dRegno1==eRd) | (dUsesRs2 & dRegno2==eRd)). There is no r0 exemption.

State behaviour:
- **STARTUP:**
  - Outputs: fetchEn=0, decodeFlush=1, execFlush=1, all other enables 1, wbBubble=0.
  - An internal counter advances once per edge.
  - After STARTUP_CYCLES edges the state moves to RUN.
  - The hazard inputs are ignored.
- **RUN / MEM_WAIT:** outputs are combinational, in this priority order:
  1. mBusy=1: fetchEn=decodeEn=execEn=memEn=0, wbBubble=1, no flushes.
     - A pending eRedirect or loadUse stays frozen in place and is acted on in the first cycle with mBusy=0.
  2. eRedirect=1: all enables 1, decodeFlush=1, execFlush=1.
     - A simultaneous loadUse is ignored, because the Decode instruction is wrong-path.
  3. loadUse=1: fetchEn=0, decodeEn=0, execEn=1 with execFlush=1, memEn=1.
  4. Otherwise: all enables 1, no flush, no bubble.
- **Transitions:**
  - RUN goes to MEM_WAIT at an edge with mBusy=1.
  - MEM_WAIT goes to RUN at an edge with mBusy=0.
  - STARTUP is re-entered only through reset.
- **Counters:**
  - stallCount increments at each edge where loadUse caused a stall (priority 3 taken).
  - flushCount increments at each edge where priority 2 was taken.
  - Both saturate at all-ones and never wrap.
  - Cycles frozen by mBusy are not counted.
- **Timeout:**
  - waitCnt counts consecutive edges with mBusy=1 and clears on an edge with mBusy=0.
  - memTimeout sets at the edge that completes the MEM_TIMEOUT-th consecutive busy cycle.
  - It stays set until reset; the pipeline keeps waiting.

## Timing
- Reset values:
  - state=STARTUP, counters/waitCnt=0, memTimeout=0.
  - While reset=0, outputs hold the STARTUP values: fetchEn=0, decodeFlush=execFlush=1, decodeEn=execEn=memEn=1, wbBubble=0.
- Reset asserted mid-operation, in any state, forces these values asynchronously, with no wait for a clock edge.
- Enable/flush outputs are same-cycle combinational from inputs and state (zero latency). The register banks act on them at the next rising edge.
- A load-use stall lasts exactly one cycle: after the edge, the load is in Mem and the forwarding path covers the dependence.
- A redirect flush lasts exactly one cycle per eRedirect pulse.
- state, counters and memTimeout are registered; they update at the rising edge following the causing cycle.
- First fetchEn=1 occurs in the cycle after the STARTUP_CYCLES-th rising edge following reset release.

## Test plan
- Release reset with STARTUP_CYCLES=4 -> fetchEn=0, decodeFlush=execFlush=1 through 4 edges; then state=1 and fetchEn=1.
- In RUN, eIsLoad=1, eRegfileWrtEn=1, eRd=5, dUsesRs2=1, dRegno2=5 for one cycle -> fetchEn=0, decodeEn=0, execFlush=1 that cycle only; stallCount goes 0->1. Repeat with dUsesRs2=0 -> no stall.
- eRedirect=1 together with the load-use condition above -> decodeFlush=execFlush=1, fetchEn=1; flushCount+1, stallCount unchanged.
- mBusy=1 for 3 cycles with MEM_TIMEOUT=2 and eRedirect=1 held -> all enables 0 and wbBubble=1 for those 3 cycles; state=2 after the first edge; memTimeout=1 after the 2nd busy edge, and still 1 later. The flush occurs in the 4th cycle; state returns to 1.
- Assert reset during MEM_WAIT between clock edges -> STARTUP outputs immediately, counters=0, memTimeout=0, state=0.
- CNT_BITS=4, 20 separate load-use stalls -> stallCount=15, with no wrap.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and sequencing controller for the 5-stage pipeline
// (Fetch, Decode, Exec, Mem, WB). Drives the load enables and bubble
// controls of every inter-stage register bank. It also keeps saturating
// stall/flush counters and a sticky memory-timeout flag for debug.
//
// Ports:
//   clk                        pipeline clock
//   reset                      asynchronous, active-low reset
//   dRegno1, dRegno2           source registers of the Decode instruction
//   dUsesRs1, dUsesRs2         Decode instruction actually reads that source
//   eRd                        destination register of the Exec instruction
//   eRegfileWrtEn              Exec instruction writes the regfile
//   eIsLoad                    Exec instruction is a load
//   eRedirect                  Exec resolved a taken branch/jump
//   mBusy                      Mem stage access not complete this cycle
//   fetchEn/decodeEn/execEn/memEn   load enables for PC, D, E, M banks
//   decodeFlush, execFlush     D/E bank loads a bubble instead of its input
//   wbBubble                   WB bank loads a bubble
//   state                      0=STARTUP, 1=RUN, 2=MEM_WAIT
//   stallCount, flushCount     saturating event counters
//   memTimeout                 sticky Mem-busy timeout flag
module pipeline_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int CNT_BITS            = 16,
  parameter int STARTUP_CYCLES      = 4,
  parameter int MEM_TIMEOUT         = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dRegno1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dRegno2,
  input  logic                           dUsesRs1,
  input  logic                           dUsesRs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] eRd,
  input  logic                           eRegfileWrtEn,
  input  logic                           eIsLoad,
  input  logic                           eRedirect,
  input  logic                           mBusy,
  output logic                           fetchEn,
  output logic                           decodeEn,
  output logic                           execEn,
  output logic                           memEn,
  output logic                           decodeFlush,
  output logic                           execFlush,
  output logic                           wbBubble,
  output logic [1:0]                     state,
  output logic [CNT_BITS-1:0]            stallCount,
  output logic [CNT_BITS-1:0]            flushCount,
  output logic                           memTimeout
);

  localparam int SU_W   = $clog2(STARTUP_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_STARTUP  = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t              cur_state;
  logic [SU_W-1:0]     su_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                load_use;
  logic                take_stall;
  logic                take_flush;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // No r0 exemption: a load targeting r0 still stalls a dependent reader.
  assign load_use = eIsLoad & eRegfileWrtEn &
                    ((dUsesRs1 & (dRegno1 == eRd)) | (dUsesRs2 & (dRegno2 == eRd)));

  assign state = cur_state;

  // Zero-latency control; the register banks act on it at the next edge.
  // Reset forces cur_state to STARTUP asynchronously, so these outputs
  // switch to the start-up pattern without waiting for a clock.
  always_comb begin
    fetchEn     = 1'b1;
    decodeEn    = 1'b1;
    execEn      = 1'b1;
    memEn       = 1'b1;
    decodeFlush = 1'b0;
    execFlush   = 1'b0;
    wbBubble    = 1'b0;
    take_stall  = 1'b0;
    take_flush  = 1'b0;
    if (cur_state == ST_STARTUP) begin
      fetchEn     = 1'b0;
      decodeFlush = 1'b1;
      execFlush   = 1'b1;
    end else if (mBusy) begin
      // Freeze everything upstream of WB; a pending redirect or load-use
      // stays in place and is handled once the access completes.
      fetchEn  = 1'b0;
      decodeEn = 1'b0;
      execEn   = 1'b0;
      memEn    = 1'b0;
      wbBubble = 1'b1;
    end else if (eRedirect) begin
      // Decode holds a wrong-path instruction, so any load-use is moot.
      decodeFlush = 1'b1;
      execFlush   = 1'b1;
      take_flush  = 1'b1;
    end else if (load_use) begin
      fetchEn    = 1'b0;
      decodeEn   = 1'b0;
      execFlush  = 1'b1;
      take_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state  <= ST_STARTUP;
      su_cnt     <= '0;
      wait_cnt   <= '0;
      stallCount <= '0;
      flushCount <= '0;
      memTimeout <= 1'b0;
    end else begin
      case (cur_state)
        ST_STARTUP: begin
          if (su_cnt == SU_W'(STARTUP_CYCLES - 1)) cur_state <= ST_RUN;
          else                                     su_cnt    <= su_cnt + SU_W'(1);
        end
        ST_RUN:      if (mBusy)  cur_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (!mBusy) cur_state <= ST_RUN;
        default:                 cur_state <= ST_STARTUP;
      endcase

      if (take_stall) stallCount <= sat_inc(stallCount);
      if (take_flush) flushCount <= sat_inc(flushCount);

      // Consecutive-busy counter parks at MEM_TIMEOUT; the flag is sticky.
      if (mBusy) begin
        if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) memTimeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: start-up drain, load-use stall, redirect
// flush, Mem freeze with timeout, asynchronous reset and counter saturation.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dRegno1, dRegno2, eRd;
  logic       dUsesRs1, dUsesRs2, eRegfileWrtEn, eIsLoad, eRedirect, mBusy;
  logic       fetchEn, decodeEn, execEn, memEn, decodeFlush, execFlush, wbBubble;
  logic [1:0] state;
  logic [3:0] stallCount, flushCount;
  logic       memTimeout;
  logic [6:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fc;
    logic       to;
  } exp_t;

  exp_t sb[$];

  // {fetchEn, decodeEn, execEn, memEn, decodeFlush, execFlush, wbBubble}
  localparam logic [6:0] STARTUP_O = 7'b0111_110;
  localparam logic [6:0] RUN_O     = 7'b1111_000;
  localparam logic [6:0] STALL_O   = 7'b0011_010;
  localparam logic [6:0] FLUSH_O   = 7'b1111_110;
  localparam logic [6:0] BUSY_O    = 7'b0000_001;

  pipeline_ctrl #(
    .REG_INDEX_BIT_WIDTH(4),
    .CNT_BITS(4),
    .STARTUP_CYCLES(4),
    .MEM_TIMEOUT(2)
  ) dut (
    .clk(clk), .reset(reset),
    .dRegno1(dRegno1), .dRegno2(dRegno2),
    .dUsesRs1(dUsesRs1), .dUsesRs2(dUsesRs2),
    .eRd(eRd), .eRegfileWrtEn(eRegfileWrtEn), .eIsLoad(eIsLoad),
    .eRedirect(eRedirect), .mBusy(mBusy),
    .fetchEn(fetchEn), .decodeEn(decodeEn), .execEn(execEn), .memEn(memEn),
    .decodeFlush(decodeFlush), .execFlush(execFlush), .wbBubble(wbBubble),
    .state(state), .stallCount(stallCount), .flushCount(flushCount),
    .memTimeout(memTimeout)
  );

  assign ctl = {fetchEn, decodeEn, execEn, memEn, decodeFlush, execFlush, wbBubble};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input logic [6:0] c, input logic [1:0] st,
                            input int sc, input int fc, input logic to);
    exp_t e;
    e.ctl = c; e.st = st; e.sc = 4'(sc); e.fc = 4'(fc); e.to = to;
    sb.push_back(e);
  endtask

  task automatic compare_now(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ctl"},   {1'b0, ctl},        {1'b0, e.ctl});
      chk({tag, "_state"}, {6'd0, state},      {6'd0, e.st});
      chk({tag, "_stall"}, {4'd0, stallCount}, {4'd0, e.sc});
      chk({tag, "_flush"}, {4'd0, flushCount}, {4'd0, e.fc});
      chk({tag, "_tmo"},   {7'd0, memTimeout}, {7'd0, e.to});
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then sample 1ns later.
  task automatic step(input string tag, input logic lu, input logic rs2,
                      input logic rd, input logic busy,
                      input logic [6:0] c, input logic [1:0] st,
                      input int sc, input int fc, input logic to);
    @(negedge clk);
    eIsLoad   = lu;
    dUsesRs2  = rs2;
    eRedirect = rd;
    mBusy     = busy;
    expect_now(c, st, sc, fc, to);
    #1;
    compare_now(tag);
  endtask

  initial begin
    int exp_sc;
    reset = 1'b0;
    dRegno1 = 4'd3; dUsesRs1 = 1'b1;
    dRegno2 = 4'd5; dUsesRs2 = 1'b0;
    eRd = 4'd5; eRegfileWrtEn = 1'b1; eIsLoad = 1'b0;
    eRedirect = 1'b0; mBusy = 1'b0;

    #1;
    expect_now(STARTUP_O, 2'd0, 0, 0, 1'b0);
    compare_now("reset");

    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_now(STARTUP_O, 2'd0, 0, 0, 1'b0);
    compare_now("su0");

    // Hazards are ignored while draining.
    step("su1", 1, 1, 1, 0, STARTUP_O, 2'd0, 0, 0, 1'b0);
    step("su2", 1, 1, 1, 0, STARTUP_O, 2'd0, 0, 0, 1'b0);
    step("su3", 1, 1, 1, 0, STARTUP_O, 2'd0, 0, 0, 1'b0);

    step("lu_stall", 1, 1, 0, 0, STALL_O, 2'd1, 0, 0, 1'b0);
    step("after_stall", 0, 0, 0, 0, RUN_O, 2'd1, 1, 0, 1'b0);
    step("lu_rs2_off", 1, 0, 0, 0, RUN_O, 2'd1, 1, 0, 1'b0);
    step("idle1", 0, 0, 0, 0, RUN_O, 2'd1, 1, 0, 1'b0);
    step("redir_lu", 1, 1, 1, 0, FLUSH_O, 2'd1, 1, 0, 1'b0);
    step("idle2", 0, 0, 0, 0, RUN_O, 2'd1, 1, 1, 1'b0);

    step("busy1", 1, 1, 1, 1, BUSY_O, 2'd1, 1, 1, 1'b0);
    step("busy2", 1, 1, 1, 1, BUSY_O, 2'd2, 1, 1, 1'b0);
    step("busy3", 1, 1, 1, 1, BUSY_O, 2'd2, 1, 1, 1'b1);
    step("busy_done_flush", 1, 1, 1, 0, FLUSH_O, 2'd2, 1, 1, 1'b1);
    step("idle3", 0, 0, 0, 0, RUN_O, 2'd1, 1, 2, 1'b1);

    // Enter MEM_WAIT, then pull reset between edges.
    step("busy4", 0, 0, 0, 1, BUSY_O, 2'd1, 1, 2, 1'b1);
    @(posedge clk);
    #3;
    expect_now(BUSY_O, 2'd2, 1, 2, 1'b1);
    compare_now("memwait");
    reset = 1'b0;
    #1;
    expect_now(STARTUP_O, 2'd0, 0, 0, 1'b0);
    compare_now("async_reset");

    @(negedge clk);
    mBusy = 1'b0; eRedirect = 1'b0; eIsLoad = 1'b0; dUsesRs2 = 1'b0;
    reset = 1'b1;
    #1;
    expect_now(STARTUP_O, 2'd0, 0, 0, 1'b0);
    compare_now("su2_0");
    step("su2_1", 0, 0, 0, 0, STARTUP_O, 2'd0, 0, 0, 1'b0);
    step("su2_2", 0, 0, 0, 0, STARTUP_O, 2'd0, 0, 0, 1'b0);
    step("su2_3", 0, 0, 0, 0, STARTUP_O, 2'd0, 0, 0, 1'b0);

    // Twenty separate stalls into a 4-bit counter: must stop at 15.
    exp_sc = 0;
    for (int i = 0; i < 20; i++) begin
      step("sat_stall", 1, 1, 0, 0, STALL_O, 2'd1, exp_sc, 0, 1'b0);
      exp_sc = (exp_sc < 15) ? exp_sc + 1 : 15;
      step("sat_idle", 0, 0, 0, 0, RUN_O, 2'd1, exp_sc, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
